// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg
//   Shared definitions for the single-PE convolution controller:
//   the sequencing FSM state encoding and the default MAC pipeline depth.
`timescale 1ns/1ps
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG   = 3'd1,
    RUN   = 3'd2,
    STEP  = 3'd3,
    DRAIN = 3'd4,
    FIN   = 3'd5
  } state_t;

  // Cycles from the last put_data until the last psum reaches the sum buffer.
  localparam int PIPE_LATENCY_DEF = 3;

endpackage

// File: rtl/drain_counter.sv
// drain_counter
//   Counts out the MAC pipeline drain. A load presets the count so that
//   exactly PIPE_LATENCY cycles elapse (including the one where zero is
//   reached) while dec is held high.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   load      preset the count to PIPE_LATENCY-1
//   dec       decrement (ignored once the count is zero)
//   zero      count is zero: final drain cycle
`timescale 1ns/1ps
module drain_counter #(
  parameter int PIPE_LATENCY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(PIPE_LATENCY + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(PIPE_LATENCY - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/conv_pe_controller.sv
// conv_pe_controller
//   Sequencing FSM for the single-PE convolution datapath. Loads the
//   stride/filter-size config, clears partial sums, issues one MAC per cycle
//   while both operands are available and the sum buffer has room, steps
//   filters/rows at window boundaries, then drains the MAC pipeline before
//   committing the final psum and pulsing done.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start, abort                command interface (abort has priority)
//   av_data, av_filter          operand availability from the scratch pads
//   co_filter, end_of_row,
//   end_of_filter               window/row/filter boundary flags (issue cycles only)
//   psum_full                   sum-buffer back-pressure
//   ld_stride, ld_filterSize,
//   clear_sum                   configuration pulses (CFG)
//   put_data, put_filter        MAC operand issue
//   next_filter, next_row       filter step pulses (STEP)
//   store_buffer                final psum commit (last DRAIN cycle)
//   busy, done                  job status
//   windows_done                windows completed in the current job
`timescale 1ns/1ps
module conv_pe_controller
  import conv_ctrl_pkg::*;
#(
  parameter int PIPE_LATENCY = PIPE_LATENCY_DEF,
  parameter int WCNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  av_data,
  input  logic                  av_filter,
  input  logic                  co_filter,
  input  logic                  end_of_row,
  input  logic                  end_of_filter,
  input  logic                  psum_full,
  output logic                  ld_stride,
  output logic                  ld_filterSize,
  output logic                  clear_sum,
  output logic                  put_data,
  output logic                  put_filter,
  output logic                  next_filter,
  output logic                  next_row,
  output logic                  store_buffer,
  output logic                  busy,
  output logic                  done,
  output logic [WCNT_WIDTH-1:0] windows_done
);

  state_t state, state_nx;
  logic   issue;
  logic   win_clr, win_inc;
  logic   drain_load, drain_dec, drain_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          windows_done <= '0;
    else if (win_clr) windows_done <= '0;
    else if (win_inc) windows_done <= windows_done + 1'b1;
  end

  drain_counter #(.PIPE_LATENCY(PIPE_LATENCY)) u_drain (
    .clk  (clk),
    .rst  (rst),
    .load (drain_load),
    .dec  (drain_dec),
    .zero (drain_zero)
  );

  assign busy = (state != IDLE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nx      = state;
    ld_stride     = 1'b0;
    ld_filterSize = 1'b0;
    clear_sum     = 1'b0;
    put_data      = 1'b0;
    put_filter    = 1'b0;
    next_filter   = 1'b0;
    next_row      = 1'b0;
    store_buffer  = 1'b0;
    done          = 1'b0;
    win_clr       = 1'b0;
    win_inc       = 1'b0;
    drain_load    = 1'b0;
    drain_dec     = 1'b0;
    issue         = av_data & av_filter & ~psum_full;

    unique case (state)
      IDLE: if (start) state_nx = CFG;
      CFG: begin
        ld_stride     = 1'b1;
        ld_filterSize = 1'b1;
        clear_sum     = 1'b1;
        win_clr       = 1'b1;
        state_nx      = RUN;
      end
      RUN: begin
        put_data   = issue;
        put_filter = issue;
        // Boundary flags describe the operand being issued, so they only
        // mean something in an issue cycle.
        if (issue && co_filter) begin
          win_inc = 1'b1;
          if (end_of_row) begin
            if (end_of_filter) begin
              drain_load = 1'b1;
              state_nx   = DRAIN;
            end else begin
              state_nx = STEP;
            end
          end
        end
      end
      STEP: begin
        next_filter = 1'b1;
        next_row    = 1'b1;
        state_nx    = RUN;
      end
      DRAIN: begin
        drain_dec = 1'b1;
        if (drain_zero) begin
          store_buffer = 1'b1;
          state_nx     = FIN;
        end
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Abort wins over everything: no pulse escapes and the window count holds.
    if (abort) begin
      state_nx      = IDLE;
      ld_stride     = 1'b0;
      ld_filterSize = 1'b0;
      clear_sum     = 1'b0;
      put_data      = 1'b0;
      put_filter    = 1'b0;
      next_filter   = 1'b0;
      next_row      = 1'b0;
      store_buffer  = 1'b0;
      done          = 1'b0;
      win_clr       = 1'b0;
      win_inc       = 1'b0;
      drain_load    = 1'b0;
      drain_dec     = 1'b0;
    end
  end

endmodule
